// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with registered read port and status/handshake flags
//
// Purpose: DEPTH x DATA_W FIFO with separate write and read pointers. An
//   independent occupancy counter removes any full/empty ambiguity. All status
//   flags are registered from the next-state count, so they always agree with
//   data_count.
//
// Optional feature macro: SYNC_FIFO_HANDSHAKE_EN
//   defined   : wr_ack, overflow, valid and underflow are registered pulses
//   undefined : those four outputs are tied to 0
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous assert, active-low reset
//   din          in   write data
//   wr_en        in   write request
//   rd_en        in   read request
//   dout         out  registered read data, held when no read is accepted
//   full         out  count == DEPTH
//   almost_full  out  count >= DEPTH-1
//   empty        out  count == 0
//   almost_empty out  count <= 1
//   data_count   out  occupancy, 0..DEPTH
//   wr_ack       out  previous cycle's write was accepted
//   overflow     out  previous cycle's write was rejected
//   valid        out  dout updated by an accepted read
//   underflow    out  previous cycle's read was rejected

module sync_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   data_count,
  output logic              wr_ack,
  output logic              overflow,
  output logic              valid,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] DEPTH_M1  = DEPTH_C - 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q;
  logic              full_q, almost_full_q, empty_q, almost_empty_q;

  logic wr_acc;
  logic rd_acc;

  // Acceptance is judged against the registered flags, so a full FIFO with a
  // simultaneous read still rejects the write this cycle.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      if (rd_acc) dout_q <= mem[rd_ptr_q];
      full_q         <= (count_d == DEPTH_C);
      almost_full_q  <= (count_d >= DEPTH_M1);
      empty_q        <= (count_d == '0);
      almost_empty_q <= (count_d <= {{ADDR_W{1'b0}}, 1'b1});
    end
  end

  assign dout         = dout_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign data_count   = count_q;

`ifdef SYNC_FIFO_HANDSHAKE_EN
  logic wr_ack_q, overflow_q, valid_q, underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && !wr_acc;
      valid_q     <= rd_acc;
      underflow_q <= rd_en && !rd_acc;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign valid     = valid_q;
  assign underflow = underflow_q;
`else
  assign wr_ack    = 1'b0;
  assign overflow  = 1'b0;
  assign valid     = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl

module tb_sync_fifo_ctrl;

`ifdef SYNC_FIFO_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full, almost_full, empty, almost_empty;
  logic [ADDR_W:0]   data_count;
  logic              wr_ack, overflow, valid, underflow;

  sync_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .valid        (valid),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_q[$];
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_wr_ack, m_ovf, m_valid, m_unf;
  int         pulses_wr_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},        32'(data_count),   32'(m_cnt));
    check({tag, ".full"},         32'(full),         32'(m_cnt == DEPTH));
    check({tag, ".almost_full"},  32'(almost_full),  32'(m_cnt >= DEPTH - 1));
    check({tag, ".empty"},        32'(empty),        32'(m_cnt == 0));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_cnt <= 1));
    check({tag, ".dout"},         32'(dout),         32'(m_dout));
    check({tag, ".wr_ack"},       32'(wr_ack),       32'(HS & m_wr_ack));
    check({tag, ".overflow"},     32'(overflow),     32'(HS & m_ovf));
    check({tag, ".valid"},        32'(valid),        32'(HS & m_valid));
    check({tag, ".underflow"},    32'(underflow),    32'(HS & m_unf));
  endtask

  // One clock: drive request, update model at the edge, check 1 time unit later.
  task automatic cycle(input string tag, input bit wr, input bit rd, input logic [7:0] d);
    bit wa, ra;
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    wa = wr && (m_cnt != DEPTH);
    ra = rd && (m_cnt != 0);
    if (ra) m_dout = m_q.pop_front();
    if (wa) m_q.push_back(d);
    m_cnt    = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
    m_wr_ack = wa;
    m_ovf    = wr && !wa;
    m_valid  = ra;
    m_unf    = rd && !ra;
    if (wa) pulses_wr_ack++;
    #1;
    check_all(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt    = 0;
    m_dout   = 8'h00;
    m_wr_ack = 1'b0;
    m_ovf    = 1'b0;
    m_valid  = 1'b0;
    m_unf    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_reset();
    pulses_wr_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // fill 0x00..0xFF
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 8'(i));
    check("fill.count256", 32'(data_count), 32'd256);
    check("fill.wr_ack_pulses", 32'(pulses_wr_ack), 32'd256);

    // overflow attempt with 0xF0
    cycle("ovf", 1'b1, 1'b0, 8'hF0);
    check("ovf.pulse", 32'(overflow), 32'(HS));
    cycle("ovf_after", 1'b0, 1'b0, 8'h00);

    // drain: model checks dout 0x00..0xFF in order, never 0xF0 at the end
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
    check("drain.last_dout", 32'(dout), 32'hFF);

    // underflow: dout must hold 0xFF
    cycle("unf", 1'b0, 1'b1, 8'h00);
    check("unf.dout_hold", 32'(dout), 32'hFF);
    cycle("unf_after", 1'b0, 1'b0, 8'h00);

    // count 5, simultaneous traffic for 10 cycles
    for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) cycle("both5", 1'b1, 1'b1, 8'(8'h20 + i));
    check("both5.count", 32'(data_count), 32'd5);

    // top up to full, then simultaneous at full
    for (int i = 0; i < DEPTH - 5; i++) cycle("topup", 1'b1, 1'b0, 8'(8'h40 + i));
    check("topup.full", 32'(full), 32'd1);
    cycle("both_full", 1'b1, 1'b1, 8'hEE);
    check("both_full.count", 32'(data_count), 32'd255);

    // drain everything, then simultaneous at empty
    for (int i = 0; i < DEPTH - 1; i++) cycle("drain2", 1'b0, 1'b1, 8'h00);
    check("drain2.empty", 32'(empty), 32'd1);
    cycle("both_empty", 1'b1, 1'b1, 8'h3C);
    check("both_empty.count", 32'(data_count), 32'd1);

    // fill to 100, then asynchronous reset off the clock edge
    for (int i = 0; i < 99; i++) cycle("fill100", 1'b1, 1'b0, 8'(i));
    check("fill100.count", 32'(data_count), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    cycle("post_wr", 1'b1, 1'b0, 8'hA5);
    cycle("post_rd", 1'b0, 1'b1, 8'h00);
    check("post.dout_a5", 32'(dout), 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
